// File: rtl/param_alu.sv
// Parameterised ALU with sticky status flags and a WIDTH-cycle shift-add multiplier.
// One request in flight; results and flags land together with the out_valid pulse.
module param_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       flag,
  output logic             illegal
);

  // state    | meaning
  // IDLE     | ready for a request; in_ready high
  // MUL_BUSY | shift-add multiply in progress, one partial product per cycle
  // DONE     | outputs valid for one cycle; out_valid high

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_CMP = 4'b0110;
  localparam logic [3:0] OP_ADC = 4'b0111;
  localparam logic [3:0] OP_SBB = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    DONE
  } state_t;

  state_t state, state_next;

  logic                   accept;
  logic                   carry_in;
  logic                   borrow_in;
  logic [WIDTH:0]         add_sum;
  logic [WIDTH:0]         sub_diff;
  logic [2*WIDTH-1:0]     mul_acc;
  logic [2*WIDTH-1:0]     mul_mcand;
  logic [2*WIDTH-1:0]     mul_sum;
  logic [WIDTH-1:0]       mul_mplier;
  logic [CW-1:0]          mul_cnt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);

  assign carry_in  = (opcode == OP_ADC) ? flag[1] : 1'b0;
  assign borrow_in = (opcode == OP_SBB) ? flag[0] : 1'b0;
  assign add_sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  // The MSB of the widened difference is the borrow, i.e. a < b + borrow_in.
  assign sub_diff  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, borrow_in};
  assign mul_sum   = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (opcode == OP_MUL) ? MUL_BUSY : DONE;
        end
      end
      MUL_BUSY: begin
        if (mul_cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result     <= '0;
      result_hi  <= '0;
      flag       <= '0;
      illegal    <= 1'b0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (opcode != OP_MUL) begin
              result_hi <= '0;
              illegal   <= 1'b0;
            end
            case (opcode)
              OP_ADD, OP_ADC: begin
                result  <= add_sum[WIDTH-1:0];
                flag[1] <= add_sum[WIDTH];
              end
              OP_SUB, OP_SBB: begin
                result  <= sub_diff[WIDTH-1:0];
                flag[0] <= sub_diff[WIDTH];
              end
              OP_AND: result <= a & b;
              OP_OR:  result <= a | b;
              OP_XOR: result <= a ^ b;
              OP_CMP: begin
                result    <= '0;
                flag[4:2] <= (a < b) ? 3'b100 : ((a > b) ? 3'b010 : 3'b001);
              end
              OP_MUL: begin
                mul_acc    <= '0;
                mul_mcand  <= {{WIDTH{1'b0}}, a};
                mul_mplier <= b;
                mul_cnt    <= CW'(WIDTH - 1);
              end
              default: begin
                result  <= '0;
                illegal <= 1'b1;
              end
            endcase
          end
        end
        MUL_BUSY: begin
          mul_acc    <= mul_sum;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt - 1'b1;
          // Results are only committed on the last step so an aborted multiply leaves no trace.
          if (mul_cnt == '0) begin
            {result_hi, result} <= mul_sum;
            illegal             <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_alu.sv
// Directed bench for param_alu: a WIDTH=4 and a WIDTH=8 instance driven from one
// linear sequence, checked with immediate assertions against hand-computed values.
module tb_param_alu;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_CMP = 4'b0110;
  localparam logic [3:0] OP_ADC = 4'b0111;
  localparam logic [3:0] OP_SBB = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_BAD = 4'b1111;

  logic       clk = 1'b0;
  logic       reset4, reset8;
  logic       in_valid4, in_valid8;
  logic [3:0] opcode;
  logic [7:0] a_in, b_in;

  logic       in_ready4, out_valid4, illegal4;
  logic [3:0] result4, result_hi4;
  logic [4:0] flag4;
  logic       in_ready8, out_valid8, illegal8;
  logic [7:0] result8, result_hi8;
  logic [4:0] flag8;

  logic sel8;
  logic obs_ready, obs_ov;
  assign obs_ready = sel8 ? in_ready8 : in_ready4;
  assign obs_ov    = sel8 ? out_valid8 : out_valid4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_alu #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset4), .in_valid(in_valid4), .in_ready(in_ready4),
    .opcode(opcode), .a(a_in[3:0]), .b(b_in[3:0]), .out_valid(out_valid4),
    .result(result4), .result_hi(result_hi4), .flag(flag4), .illegal(illegal4)
  );

  param_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .in_valid(in_valid8), .in_ready(in_ready8),
    .opcode(opcode), .a(a_in), .b(b_in), .out_valid(out_valid8),
    .result(result8), .result_hi(result_hi8), .flag(flag8), .illegal(illegal8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one request to the selected instance, then counts negedges until out_valid.
  task automatic issue(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                       output int lat, output bit busy_ok);
    int guard;
    guard = 0;
    @(negedge clk);
    opcode = op;
    a_in   = av;
    b_in   = bv;
    if (sel8) in_valid8 = 1'b1;
    else      in_valid4 = 1'b1;
    while (!obs_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (obs_ov) break;
      if (obs_ready) busy_ok = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  busy_ok;
    int  accepts, ovs, consec, abort_ov;
    logic prev_ov;

    sel8 = 1'b0;
    reset4 = 1'b1;
    reset8 = 1'b1;
    in_valid4 = 1'b1;
    in_valid8 = 1'b1;
    opcode = OP_ADD;
    a_in = 8'd1;
    b_in = 8'd1;
    repeat (3) @(negedge clk);
    chk("rst.busy_ov", {31'd0, out_valid4}, 32'd0);
    reset4 = 1'b0;
    reset8 = 1'b0;
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
    @(negedge clk);
    chk("rst.ready",   {31'd0, in_ready4}, 32'd1);
    chk("rst.ov",      {31'd0, out_valid4}, 32'd0);
    chk("rst.result",  result4, 32'd0);
    chk("rst.hi",      result_hi4, 32'd0);
    chk("rst.flag",    flag4, 32'd0);
    chk("rst.illegal", {31'd0, illegal4}, 32'd0);
    chk("rst.ready8",  {31'd0, in_ready8}, 32'd1);
    @(negedge clk);
    chk("rst.noaccept", {31'd0, out_valid4}, 32'd0);

    issue(OP_ADD, 8'd9, 8'd8, lat, busy_ok);
    chk("add.lat",  lat, 32'd1);
    chk("add.res",  result4, 32'd1);
    chk("add.flag", flag4, 32'b00010);
    chk("add.hi",   result_hi4, 32'd0);

    issue(OP_ADC, 8'd2, 8'd3, lat, busy_ok);
    chk("adc.res",  result4, 32'd6);
    chk("adc.flag", flag4, 32'b00000);

    issue(OP_SUB, 8'd3, 8'd5, lat, busy_ok);
    chk("sub.lat",  lat, 32'd1);
    chk("sub.res",  result4, 32'd14);
    chk("sub.flag", flag4, 32'b00001);

    issue(OP_SBB, 8'd5, 8'd5, lat, busy_ok);
    chk("sbb.res",  result4, 32'd15);
    chk("sbb.flag", flag4, 32'b00001);

    issue(OP_ADD, 8'd9, 8'd8, lat, busy_ok);
    chk("add2.flag", flag4, 32'b00011);

    issue(OP_CMP, 8'd7, 8'd7, lat, busy_ok);
    chk("cmp_eq.res",  result4, 32'd0);
    chk("cmp_eq.flag", flag4, 32'b00111);

    issue(OP_CMP, 8'd3, 8'd9, lat, busy_ok);
    chk("cmp_lt.flag", flag4, 32'b10011);

    issue(OP_CMP, 8'd9, 8'd3, lat, busy_ok);
    chk("cmp_gt.flag", flag4, 32'b01011);

    issue(OP_AND, 8'd12, 8'd10, lat, busy_ok);
    chk("and.res",  result4, 32'd8);
    chk("and.flag", flag4, 32'b01011);

    issue(OP_OR, 8'd12, 8'd10, lat, busy_ok);
    chk("or.res", result4, 32'd14);

    issue(OP_MUL, 8'd15, 8'd15, lat, busy_ok);
    chk("mul4.lat",  lat, 32'd5);
    chk("mul4.busy", {31'd0, busy_ok}, 32'd1);
    chk("mul4.hi",   result_hi4, 32'd14);
    chk("mul4.res",  result4, 32'd1);
    chk("mul4.flag", flag4, 32'b01011);

    issue(OP_BAD, 8'd5, 8'd5, lat, busy_ok);
    chk("bad.lat",     lat, 32'd1);
    chk("bad.illegal", {31'd0, illegal4}, 32'd1);
    chk("bad.res",     result4, 32'd0);
    chk("bad.hi",      result_hi4, 32'd0);
    chk("bad.flag",    flag4, 32'b01011);
    @(negedge clk);
    chk("bad.pulse",   {31'd0, out_valid4}, 32'd0);
    chk("bad.hold",    {31'd0, illegal4}, 32'd1);

    issue(OP_XOR, 8'd12, 8'd10, lat, busy_ok);
    chk("xor.res",     result4, 32'd6);
    chk("xor.illegal", {31'd0, illegal4}, 32'd0);

    @(negedge clk);
    opcode = OP_ADD;
    a_in = 8'd1;
    b_in = 8'd1;
    in_valid4 = 1'b1;
    accepts = 0;
    ovs = 0;
    consec = 0;
    prev_ov = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (in_ready4) accepts++;
      if (out_valid4) begin
        ovs++;
        if (prev_ov) consec++;
      end
      prev_ov = out_valid4;
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    chk("stream.accepts", accepts, 32'd6);
    chk("stream.ovs",     ovs, 32'd6);
    chk("stream.consec",  consec, 32'd0);
    chk("stream.res",     result4, 32'd2);

    sel8 = 1'b1;
    issue(OP_ADD, 8'd200, 8'd100, lat, busy_ok);
    chk("add8.res",  result8, 32'd44);
    chk("add8.flag", flag8, 32'b00010);

    issue(OP_MUL, 8'd200, 8'd3, lat, busy_ok);
    chk("mul8.lat",  lat, 32'd9);
    chk("mul8.busy", {31'd0, busy_ok}, 32'd1);
    chk("mul8.hi",   result_hi8, 32'd2);
    chk("mul8.res",  result8, 32'd88);
    chk("mul8.flag", flag8, 32'b00010);

    @(negedge clk);
    opcode = OP_MUL;
    a_in = 8'd7;
    b_in = 8'd9;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    repeat (4) @(negedge clk);
    reset8 = 1'b1;
    @(negedge clk);
    reset8 = 1'b0;
    abort_ov = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid8) abort_ov++;
      @(negedge clk);
    end
    chk("abort.ov",    abort_ov, 32'd0);
    chk("abort.flag",  flag8, 32'b00000);
    chk("abort.res",   result8, 32'd0);
    chk("abort.hi",    result_hi8, 32'd0);
    chk("abort.ready", {31'd0, in_ready8}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  request present on opcode/a/b.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 opcode  input  4  operation select.
REQ-007 a  input  WIDTH  operand A, unsigned.
REQ-008 b  input  WIDTH  operand B, unsigned.
REQ-009 out_valid  output  1  one-cycle pulse; result/result_hi/illegal are valid.
REQ-010 result  output  WIDTH  low result word.
REQ-011 result_hi  output  WIDTH  high product word for MUL; zero for every other opcode.
REQ-012 flag  output  5  sticky status: [4] less, [3] greater, [2] equal, [1] carry, [0] borrow.
REQ-013 illegal  output  1  qualifies out_valid; request carried an undefined opcode.

Function
REQ-014 Opcodes SHALL be: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 CMP, 0111 ADC, 1000 SBB, 1001 MUL; all others undefined.
REQ-015 A request SHALL be accepted when in_valid and in_ready are both high at a rising edge; opcode/a/b SHALL be captured then and ignored afterwards.
REQ-016 FSM states SHALL be IDLE, MUL_BUSY, DONE; in_ready SHALL be high only in IDLE.
REQ-017 IDLE + accepted non-MUL: compute and register outputs, go to DONE; out_valid high for exactly the following cycle (latency 1).
REQ-018 IDLE + accepted MUL: go to MUL_BUSY, run shift-add for exactly WIDTH cycles, then DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-019 DONE SHALL last one cycle with out_valid=1, then return to IDLE; back-to-back single-cycle requests: one accepted every 2 cycles.
REQ-020 ADD: result = (a+b) mod 2^WIDTH; flag[1] = carry-out; carry-in 0.
REQ-021 ADC: as ADD with carry-in = flag[1] value before the operation.
REQ-022 SUB: result = (a-b) mod 2^WIDTH; flag[0] = 1 iff a<b; borrow-in 0.
REQ-023 SBB: result = (a-b-flag[0]) mod 2^WIDTH; flag[0] = 1 iff a < b+flag[0] (full-precision compare).
REQ-024 AND/OR/XOR: bitwise result; flags unchanged.
REQ-025 CMP: result = 0; flag[4:2] SHALL be one-hot: 100 a<b, 010 a>b, 001 a==b; flag[1:0] unchanged.
REQ-026 MUL: {result_hi,result} = a*b (unsigned, 2*WIDTH bits, exact); flags unchanged.
REQ-027 Only CMP changes flag[4:2]; only ADD/ADC change flag[1]; only SUB/SBB change flag[0].
REQ-028 Flags SHALL update in the same cycle the result registers update (visible with out_valid).
REQ-029 Undefined opcode: result=0, result_hi=0, flags unchanged, illegal=1 with out_valid at latency 1.
REQ-030 result, result_hi, illegal SHALL hold their values until the next completion; illegal cleared on next legal completion.
REQ-031 in_valid while in_ready=0 SHALL be ignored (not queued); the requester keeps it asserted until in_ready.

Reset
REQ-032 reset=1 at an edge: state IDLE, in_ready=1 next cycle, out_valid=0, result=0, result_hi=0, flag=00000, illegal=0.
REQ-033 reset SHALL override any in-progress MUL or DONE; the aborted operation SHALL produce no out_valid and no flag change.
REQ-034 reset with in_valid high SHALL not accept the request.

Verification
REQ-035 WIDTH=4: ADD a=9,b=8 -> result=1, flag[1]=1; then ADC a=2,b=3 -> result=6, flag[1]=0.
REQ-036 WIDTH=4: SUB a=3,b=5 -> result=14, flag[0]=1; then SBB a=5,b=5 -> result=15, flag[0]=1; CMP a=7,b=7 -> flag[4:2]=001, flag[1:0]=11.
REQ-037 WIDTH=4: MUL a=15,b=15 -> result_hi=14, result=1, out_valid exactly 5 cycles after acceptance, in_ready=0 throughout.
REQ-038 WIDTH=8: MUL a=200,b=3 -> result_hi=2, result=88 at 9 cycles; reset asserted 4 cycles into a second MUL -> no out_valid, flag=00000.
REQ-039 Opcode 1111, a=5,b=5 -> out_valid with illegal=1, result=0, flags unchanged; next XOR a=12,b=10 -> result=6, illegal=0.
REQ-040 in_valid held high continuously with ADD stream -> acceptances every 2nd cycle, out_valid never on consecutive cycles.
